// File: rtl/reorder_buffer_pkg.sv
// ----------------------------------------------------------------------------
// reorder_buffer_pkg
// Types and helpers shared by the reorder buffer and its users.
//   addr_t       : instruction / branch-target address
//   rob_entry_t  : payload held per ROB entry (complete is owned by the ROB)
//   popcount()   : number of set lanes in a per-lane strobe vector
//                  (up to MAX_LANES lanes, zero-extend narrower vectors)
// ----------------------------------------------------------------------------
package reorder_buffer_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_LANES = 8;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        logic  is_branch;
        logic  complete;
        logic  branch_taken;
        addr_t branch_target;
    } rob_entry_t;

    function automatic logic [3:0] popcount(input logic [MAX_LANES-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < int'(MAX_LANES); i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// ----------------------------------------------------------------------------
// reorder_buffer
// Circular in-order reorder buffer. Dispatch allocates up to WIDTH entries
// per cycle at the tail, the CDB marks entries complete and records branch
// outcomes, the WIDTH oldest entries are presented to retire, and retire's
// commit prefix / mispredict flush advance the head or empty the buffer.
//
// Parameters: ROB_SZ (entries, power of two, >= 2*WIDTH), WIDTH (lanes).
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   dispatch_valids/entries      allocate request (prefix) and payload
//   dispatch_idxs                index assigned to each dispatch lane
//   free_slots                   ROB_SZ - count, from registered state
//   cdb_valids/idxs/branch_*     completion strobes and branch outcome
//   head_entries/valids/idxs     head window, lane 0 = oldest
//   retire_valids                commit prefix from retire
//   mispredict, rob_mispred_idx  flush; the branch at rob_mispred_idx commits
//   full, empty                  occupancy flags
//
// Optional build macro ROB_CDB_BYPASS_EN: same-cycle CDB completions are
// forwarded into head_entries so retire can commit in the completion cycle.
// Without it there is a one-cycle completion-to-retire bubble.
// ----------------------------------------------------------------------------
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter  int unsigned ROB_SZ = 32,
    parameter  int unsigned WIDTH  = 3,
    localparam int unsigned IDX_W  = $clog2(ROB_SZ),
    localparam int unsigned CNT_W  = $clog2(ROB_SZ + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            dispatch_valids,
    input  rob_entry_t [WIDTH-1:0]      dispatch_entries,
    output logic [WIDTH-1:0][IDX_W-1:0] dispatch_idxs,
    output logic [CNT_W-1:0]            free_slots,
    input  logic [WIDTH-1:0]            cdb_valids,
    input  logic [WIDTH-1:0][IDX_W-1:0] cdb_idxs,
    input  logic [WIDTH-1:0]            cdb_branch_taken,
    input  addr_t [WIDTH-1:0]           cdb_branch_target,
    output rob_entry_t [WIDTH-1:0]      head_entries,
    output logic [WIDTH-1:0]            head_valids,
    output logic [WIDTH-1:0][IDX_W-1:0] head_idxs,
    input  logic [WIDTH-1:0]            retire_valids,
    input  logic                        mispredict,
    input  logic [IDX_W-1:0]            rob_mispred_idx,
    output logic                        full,
    output logic                        empty
);

    logic [IDX_W-1:0]  head_q, head_d;
    logic [IDX_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ROB_SZ-1:0] valid_q, valid_d;
    rob_entry_t        entries_q [ROB_SZ];

    rob_entry_t [WIDTH-1:0] disp_wr;
    logic [3:0]             n_disp;
    logic [3:0]             n_ret;
    logic                   alloc;

    assign n_disp     = popcount(MAX_LANES'(dispatch_valids));
    assign n_ret      = popcount(MAX_LANES'(retire_valids));
    assign free_slots = CNT_W'(ROB_SZ) - count_q;
    assign full       = (count_q == CNT_W'(ROB_SZ));
    assign empty      = (count_q == '0);

    // A dispatch group is taken whole or not at all; a full buffer simply
    // stalls it. Mispredict drops any same-cycle dispatch.
    assign alloc = !mispredict && (n_disp != 4'd0) && (CNT_W'(n_disp) <= free_slots);

    always_comb begin
        for (int w = 0; w < int'(WIDTH); w++) begin
            dispatch_idxs[w]  = tail_q + IDX_W'(w);
            head_idxs[w]      = head_q + IDX_W'(w);
            head_valids[w]    = (CNT_W'(w) < count_q);
            disp_wr[w]          = dispatch_entries[w];
            disp_wr[w].complete = 1'b0;
        end
    end

    always_comb begin
        for (int w = 0; w < int'(WIDTH); w++) begin
            head_entries[w] = entries_q[head_idxs[w]];
`ifdef ROB_CDB_BYPASS_EN
            for (int c = 0; c < int'(WIDTH); c++) begin
                if (cdb_valids[c] && valid_q[cdb_idxs[c]] && (cdb_idxs[c] == head_idxs[w])) begin
                    head_entries[w].complete      = 1'b1;
                    head_entries[w].branch_taken  = cdb_branch_taken[c];
                    head_entries[w].branch_target = cdb_branch_target[c];
                end
            end
`endif
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (mispredict) begin
            // Everything younger than the branch is discarded; the branch and
            // older lanes commit, so the buffer restarts just past the branch.
            head_d  = rob_mispred_idx + IDX_W'(1);
            tail_d  = rob_mispred_idx + IDX_W'(1);
            count_d = '0;
            valid_d = '0;
        end else begin
            for (int w = 0; w < int'(WIDTH); w++) begin
                if (retire_valids[w]) begin
                    valid_d[head_q + IDX_W'(w)] = 1'b0;
                end
                if (alloc && dispatch_valids[w]) begin
                    valid_d[tail_q + IDX_W'(w)] = 1'b1;
                end
            end
            head_d  = head_q + IDX_W'(n_ret);
            tail_d  = alloc ? (tail_q + IDX_W'(n_disp)) : tail_q;
            count_d = count_q + (alloc ? CNT_W'(n_disp) : CNT_W'(0)) - CNT_W'(n_ret);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Payload storage is not reset; the valid bits alone decide what is live.
    // Completions to invalid entries are dropped, which also covers the empty
    // buffer and slots freed by a flush.
    always_ff @(posedge clock) begin
        if (!mispredict) begin
            for (int w = 0; w < int'(WIDTH); w++) begin
                if (alloc && dispatch_valids[w]) begin
                    entries_q[tail_q + IDX_W'(w)] <= disp_wr[w];
                end
            end
            for (int c = 0; c < int'(WIDTH); c++) begin
                if (cdb_valids[c] && valid_q[cdb_idxs[c]]) begin
                    entries_q[cdb_idxs[c]].complete      <= 1'b1;
                    entries_q[cdb_idxs[c]].branch_taken  <= cdb_branch_taken[c];
                    entries_q[cdb_idxs[c]].branch_target <= cdb_branch_target[c];
                end
            end
        end
    end

`ifndef SYNTHESIS
    // A partial overflow is illegal; a completely full buffer just stalls.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (mispredict || (free_slots == '0) || (CNT_W'(n_disp) <= free_slots));
            assert (CNT_W'(n_ret) <= count_q);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int SZ = 8;
    localparam int W  = 3;

    logic                 clock;
    logic                 reset;
    logic [W-1:0]         dispatch_valids;
    rob_entry_t [W-1:0]   dispatch_entries;
    logic [W-1:0][2:0]    dispatch_idxs;
    logic [3:0]           free_slots;
    logic [W-1:0]         cdb_valids;
    logic [W-1:0][2:0]    cdb_idxs;
    logic [W-1:0]         cdb_branch_taken;
    addr_t [W-1:0]        cdb_branch_target;
    rob_entry_t [W-1:0]   head_entries;
    logic [W-1:0]         head_valids;
    logic [W-1:0][2:0]    head_idxs;
    logic [W-1:0]         retire_valids;
    logic                 mispredict;
    logic [2:0]           rob_mispred_idx;
    logic                 full;
    logic                 empty;

    reorder_buffer #(.ROB_SZ(SZ), .WIDTH(W)) dut (
        .clock             (clock),
        .reset             (reset),
        .dispatch_valids   (dispatch_valids),
        .dispatch_entries  (dispatch_entries),
        .dispatch_idxs     (dispatch_idxs),
        .free_slots        (free_slots),
        .cdb_valids        (cdb_valids),
        .cdb_idxs          (cdb_idxs),
        .cdb_branch_taken  (cdb_branch_taken),
        .cdb_branch_target (cdb_branch_target),
        .head_entries      (head_entries),
        .head_valids       (head_valids),
        .head_idxs         (head_idxs),
        .retire_valids     (retire_valids),
        .mispredict        (mispredict),
        .rob_mispred_idx   (rob_mispred_idx),
        .full              (full),
        .empty             (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: the ROB is an ordered list of live entries, oldest first.
    typedef struct {
        int         idx;
        rob_entry_t e;
    } ment_t;
    ment_t mq[$];
    int    mhead = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rob_entry_t rnd_entry();
        rob_entry_t e;
        e.pc            = $urandom;
        e.is_branch     = 1'($urandom_range(0, 1));
        e.complete      = 1'b1;
        e.branch_taken  = 1'($urandom_range(0, 1));
        e.branch_target = $urandom;
        return e;
    endfunction

    task automatic set_idle();
        reset            = 1'b0;
        dispatch_valids  = '0;
        for (int w = 0; w < W; w++) dispatch_entries[w] = rnd_entry();
        cdb_valids       = '0;
        cdb_idxs         = '0;
        cdb_branch_taken = '0;
        cdb_branch_target = '0;
        retire_valids    = '0;
        mispredict       = 1'b0;
        rob_mispred_idx  = '0;
    endtask

    task automatic check_outputs();
        int sz;
        int tail;
        rob_entry_t exp;
        sz   = mq.size();
        tail = (mhead + sz) % SZ;
        chk("free_slots", 128'(free_slots), 128'(SZ - sz));
        chk("full", 128'(full), 128'(sz == SZ));
        chk("empty", 128'(empty), 128'(sz == 0));
        for (int w = 0; w < W; w++) begin
            chk($sformatf("head_valid[%0d]", w), 128'(head_valids[w]), 128'(w < sz));
            chk($sformatf("head_idx[%0d]", w), 128'(head_idxs[w]), 128'((mhead + w) % SZ));
            if (!mispredict)
                chk($sformatf("dispatch_idx[%0d]", w), 128'(dispatch_idxs[w]), 128'((tail + w) % SZ));
            if (w < sz) begin
                exp = mq[w].e;
`ifdef ROB_CDB_BYPASS_EN
                for (int c = 0; c < W; c++) begin
                    if (cdb_valids[c] && int'(cdb_idxs[c]) == mq[w].idx) begin
                        exp.complete      = 1'b1;
                        exp.branch_taken  = cdb_branch_taken[c];
                        exp.branch_target = cdb_branch_target[c];
                    end
                end
`endif
                chk($sformatf("head_entry[%0d]", w), 128'(head_entries[w]), 128'(exp));
            end
        end
    endtask

    task automatic apply_model();
        int sz0, tail0, nd, nr;
        ment_t m;
        if (reset) begin
            mq.delete();
            mhead = 0;
        end else if (mispredict) begin
            mq.delete();
            mhead = (int'(rob_mispred_idx) + 1) % SZ;
        end else begin
            sz0   = mq.size();
            tail0 = (mhead + sz0) % SZ;
            nd = 0;
            nr = 0;
            for (int w = 0; w < W; w++) begin
                if (dispatch_valids[w]) nd++;
                if (retire_valids[w]) nr++;
            end
            for (int c = 0; c < W; c++) begin
                if (cdb_valids[c]) begin
                    foreach (mq[i]) begin
                        if (mq[i].idx == int'(cdb_idxs[c])) begin
                            mq[i].e.complete      = 1'b1;
                            mq[i].e.branch_taken  = cdb_branch_taken[c];
                            mq[i].e.branch_target = cdb_branch_target[c];
                        end
                    end
                end
            end
            for (int i = 0; i < nr; i++) void'(mq.pop_front());
            mhead = (mhead + nr) % SZ;
            if (nd > 0 && nd <= SZ - sz0) begin
                for (int w = 0; w < nd; w++) begin
                    m.idx        = (tail0 + w) % SZ;
                    m.e          = dispatch_entries[w];
                    m.e.complete = 1'b0;
                    mq.push_back(m);
                end
            end
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are sampled 1
    // time unit later, then the model advances on the rising edge.
    task automatic tick();
        #1;
        check_outputs();
        @(posedge clock);
        apply_model();
        @(negedge clock);
    endtask

    initial begin
        int sz, free, nd, nr, s;
        set_idle();
        reset = 1'b1;
        @(negedge clock);
        tick();
        tick();
        reset = 1'b0;

        // 1: reset state, then dispatch three
        #1;
        chk("rst_dispatch_idxs", 128'(dispatch_idxs), 128'({3'd2, 3'd1, 3'd0}));
        chk("rst_free_slots", 128'(free_slots), 128'(8));
        dispatch_valids = 3'b111;
        tick();
        set_idle();
        tick();

        // 2: complete idx 1 only
        cdb_valids = 3'b001;
        cdb_idxs[0] = 3'd1;
        cdb_branch_taken[0] = 1'b1;
        cdb_branch_target[0] = 32'hDEAD_BEE0;
        tick();
        set_idle();
        tick();

        // 3: fill to 8, then retire 2 while dispatch is requested on a full ROB
        dispatch_valids = 3'b111;
        tick();
        dispatch_valids = 3'b011;
        tick();
        set_idle();
        #1;
        chk("full_flag", 128'(full), 128'(1));
        tick();
        retire_valids   = 3'b011;
        dispatch_valids = 3'b111;
        tick();
        set_idle();
        #1;
        chk("after_full_free", 128'(free_slots), 128'(2));
        tick();

        // 4: flush to head=6, then wrap-around dispatch and retire
        mispredict      = 1'b1;
        rob_mispred_idx = 3'd5;
        tick();
        set_idle();
        dispatch_valids = 3'b111;
        #1;
        chk("wrap_dispatch_idxs", 128'(dispatch_idxs), 128'({3'd0, 3'd7, 3'd6}));
        tick();
        set_idle();
        retire_valids = 3'b111;
        tick();
        set_idle();
        tick();

        // 5: mispredict with retire and same-cycle dispatch, then stale CDB
        reset = 1'b1;
        tick();
        set_idle();
        dispatch_valids = 3'b111;
        tick();
        dispatch_valids = 3'b011;
        tick();
        set_idle();
        mispredict      = 1'b1;
        rob_mispred_idx = 3'd1;
        retire_valids   = 3'b011;
        dispatch_valids = 3'b011;
        tick();
        set_idle();
        cdb_valids  = 3'b001;
        cdb_idxs[0] = 3'd3;
        tick();
        set_idle();
        tick();

        // 6: reset with six live entries and active dispatch/CDB
        dispatch_valids = 3'b111;
        tick();
        tick();
        reset = 1'b1;
        dispatch_valids = 3'b111;
        cdb_valids  = 3'b011;
        cdb_idxs[0] = 3'd2;
        cdb_idxs[1] = 3'd3;
        tick();
        set_idle();
        tick();

        // Randomised traffic
        for (int cyc = 0; cyc < 400; cyc++) begin
            set_idle();
            sz   = mq.size();
            free = SZ - sz;
            nd = $urandom_range(0, 3);
            if (free > 0 && nd > free) nd = free;
            dispatch_valids = 3'((1 << nd) - 1);
            nr = $urandom_range(0, (sz < 3) ? sz : 3);
            retire_valids = 3'((1 << nr) - 1);
            s = mhead + $urandom_range(0, 7);
            for (int w = 0; w < W; w++) begin
                cdb_idxs[w]          = 3'((s + w) % SZ);
                cdb_branch_taken[w]  = 1'($urandom_range(0, 1));
                cdb_branch_target[w] = $urandom;
            end
            cdb_valids = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) begin
                mispredict      = 1'b1;
                rob_mispred_idx = 3'((mhead + ((nr > 0) ? nr - 1 : 0)) % SZ);
            end
            if ($urandom_range(0, 99) == 0) reset = 1'b1;
            tick();
        end

        set_idle();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between dispatch, CDB completion and the retire stage.
- Allocates up to N entries per cycle at the tail and records completion and branch outcome from the CDB.
- Presents the N oldest entries as a head window to retire.
- Consumes retire's per-lane commit indication and its mispredict flush, then advances the head or empties the buffer.

Parameters:
- ROB_SZ, `ROB_SZ (32): number of entries; power of two, at least 2*N.
- WIDTH, `N (3): dispatch, completion, head-window and retire width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_valids  in  N  per-lane allocate request; a contiguous prefix from lane 0
- dispatch_entries  in  ROB_ENTRY[N]  entry payload; complete bit is ignored and forced 0
- dispatch_idxs  out  ROB_IDX[N]  index assigned per lane (tail+lane)
- free_slots  out  $clog2(ROB_SZ+1)  ROB_SZ minus count, from registered state
- cdb_valids  in  N  completion strobes
- cdb_idxs  in  ROB_IDX[N]  completing entry index
- cdb_branch_taken  in  N  resolved direction (meaningful for branches only)
- cdb_branch_target  in  ADDR[N]  resolved target
- head_entries  out  ROB_ENTRY[N]  lane 0 = oldest
- head_valids  out  N  lane w valid iff w < count
- head_idxs  out  ROB_IDX[N]  (head+w) mod ROB_SZ
- retire_valids  in  N  lanes committed this cycle; a contiguous prefix from lane 0
- mispredict  in  1  flush request from retire
- rob_mispred_idx  in  ROB_IDX  index of the mispredicted branch; the branch itself commits
- full  out  1  count == ROB_SZ
- empty  out  1  count == 0

Behaviour:
- State: head and tail pointers (ROB_IDX), count ($clog2(ROB_SZ+1) bits), entry array, per-entry valid bit.
- Reset, synchronous: head=tail=count=0 and all valid bits cleared. Outputs after reset: head_valids=0, free_slots=ROB_SZ, empty=1, full=0, dispatch_idxs={0,1,..,N-1}.
- Dispatch: lanes with dispatch_valids set write entries at (tail+w) mod ROB_SZ with complete=0; tail advances by popcount.
  - Dispatch must never exceed free_slots. Overflow is an assertion failure with no defined response.
- Completion: each valid CDB lane sets complete and writes branch_taken/branch_target into its entry, visible on head_entries the next cycle.
  - A completion to an invalid (flushed or free) entry is ignored.
  - Two lanes targeting the same index is illegal.
- Retire: head advances by popcount(retire_valids); those entries' valid bits clear.
- Count update: count_next = count + dispatched - retired, computed in full count width. Pointers wrap modulo ROB_SZ.
- Same-cycle dispatch and retire are both honoured. free_slots does not credit same-cycle retires.
- Mispredict takes priority over same-cycle dispatch and completion.
  - Branch and older retire lanes commit; all younger entries are discarded.
  - Next state: head = tail = (rob_mispred_idx+1) mod ROB_SZ, count = 0, all valid bits cleared.
  - Same-cycle dispatch is dropped; dispatch_idxs that cycle are don't-care.
- Full: free_slots=0 and no allocation. A simultaneous retire frees slots in the next cycle only.
- Empty: head_valids=0. A CDB write in that cycle is ignored.
- Latency: dispatch at cycle t appears in the head window at t+1. Completion at t reaches the head window at t+1.

Optional Feature:
- ROB_CDB_BYPASS_EN defined: head_entries combinationally merge same-cycle CDB completions whose index matches a head lane (complete forced 1, branch outcome from CDB), enabling retire in the completion cycle. Registered state is updated identically.
- Not defined: no forwarding; one-cycle completion-to-retire bubble.

Decomposition:
- ROB_ENTRY, ROB_IDX, ADDR, the `ROB_SZ and `N constants stay in sys_defs.svh.
- A popcount/prefix helper function goes in the shared package.
- No sub-module is natural. The head-window mux and pointer arithmetic are small and stay inline.

Test Plan:
1. Reset, then dispatch 3 entries with N=3, ROB_SZ=8 -> dispatch_idxs={0,1,2}; next cycle head_valids=3'b111, free_slots=5, complete=0.
2. CDB completes idx 1 only -> next cycle head_entries[1].complete=1 and lane 0 still incomplete. With ROB_CDB_BYPASS_EN, lane 1 shows complete in the same cycle.
3. Fill to 8 entries -> full=1, free_slots=0. Retire 2 lanes plus dispatch-valid -> no allocation that cycle; next cycle free_slots=2, head_idxs start at 2.
4. Wrap: head=6, count=0, dispatch 3 -> dispatch_idxs={6,7,0}; retire all 3 -> head=1, empty=1.
5. 5 entries at idx 0..4, mispredict with rob_mispred_idx=1 and retire_valids=2'b11, same-cycle dispatch of 2 -> next cycle empty=1, head=tail=2, dispatch dropped; a CDB strobe to idx 3 afterwards has no effect.
6. Reset asserted while 6 entries are valid and dispatch/CDB are active -> next cycle count=0, head=tail=0, free_slots=8, head_valids=0.
